// File: rtl/mem_system_assoc.sv
// mem_system_assoc: write-back, write-allocate cache controller.
// The cache is 1- or 2-way set-associative with LRU replacement.
// Tag, data, valid, dirty and LRU state are held internally. Misses refill
// the line one word at a time over a req/ack memory port. A dirty victim is
// written back over the same port before the refill starts.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   Addr, DataIn      request byte address and store data, captured on acceptance
//   Rd, Wr            load / store request strobes (exactly one per request)
//   DataOut           load data, valid while Done=1 for a load
//   Done, CacheHit    completion pulse; CacheHit=1 when no memory traffic was needed
//   Stall             controller busy; requests are ignored while high
//   err               one-cycle pulse for a malformed request, or held after mem_err
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack   word-wide memory request channel
//   mem_rvalid/mem_rdata                        memory read return (one read in flight)
//   mem_err           memory fault; the controller parks in ERR until reset
module mem_system_assoc #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int WAYS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
);

  localparam int T     = INDEX_W + OFFSET_W + 1;
  localparam int TAG_W = ADDR_W - T;
  localparam int SETS  = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;
  localparam logic [OFFSET_W-1:0] OFF0 = '0;

  generate
    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
      $error("mem_system_assoc: WAYS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESOLVE, ERR} state_t;
  state_t state;

  // Way 1 storage always exists; with WAYS=1 it is never selected.
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [DATA_W-1:0] data_mem [2][SETS][WORDS];
  logic [SETS-1:0]   valid    [2];
  logic [SETS-1:0]   dirty    [2];
  logic [SETS-1:0]   lru;          // per set: the way to evict next

  logic [ADDR_W-1:1] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              req_wr;
  logic              victim;
  logic [OFFSET_W-1:0] k, k_next;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic req_ok, req_bad;
  logic hit0, hit1, hit, hit_way, miss_victim, victim_dirty;

  assign req_tag = req_addr[ADDR_W-1:T];
  assign req_idx = req_addr[T-1:OFFSET_W+1];
  assign req_off = req_addr[OFFSET_W:1];
  assign k_next  = k + 1'b1;

  assign req_ok  = (Rd ^ Wr) && !Addr[0];
  assign req_bad = (Rd && Wr) || ((Rd || Wr) && Addr[0]);

  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] t,
                                                  input logic [INDEX_W-1:0] i,
                                                  input logic [OFFSET_W-1:0] w);
    return {t, i, w, 1'b0};
  endfunction

  always_comb begin
    hit0    = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    hit1    = (WAYS == 2) && valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    hit     = hit0 || hit1;
    hit_way = !hit0;
    // Invalid ways are filled before anything is evicted, way 0 first.
    if (!valid[0][req_idx])                      miss_victim = 1'b0;
    else if ((WAYS == 2) && !valid[1][req_idx])  miss_victim = 1'b1;
    else if (WAYS == 2)                          miss_victim = lru[req_idx];
    else                                         miss_victim = 1'b0;
    victim_dirty = valid[miss_victim][req_idx] && dirty[miss_victim][req_idx];
  end

  // Control, status and outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru      <= '0;
      DataOut  <= '0;
      Done     <= 1'b0;
      Stall    <= 1'b0;
      CacheHit <= 1'b0;
      err      <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      k        <= '0;
    end else if (mem_err) begin
      state    <= ERR;
      err      <= 1'b1;
      Stall    <= 1'b0;
      Done     <= 1'b0;
      CacheHit <= 1'b0;
      mem_req  <= 1'b0;
    end else begin
      Done     <= 1'b0;
      CacheHit <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ok) begin
            req_addr <= Addr[ADDR_W-1:1];
            req_data <= DataIn;
            req_wr   <= Wr;
            Stall    <= 1'b1;
            state    <= LOOKUP;
          end else if (req_bad) begin
            Done <= 1'b1;
            err  <= 1'b1;
          end
        end
        LOOKUP: begin
          if (hit) begin
            Done         <= 1'b1;
            CacheHit     <= 1'b1;
            Stall        <= 1'b0;
            lru[req_idx] <= ~hit_way;
            if (req_wr) dirty[hit_way][req_idx] <= 1'b1;
            else        DataOut <= data_mem[hit_way][req_idx][req_off];
            state <= IDLE;
          end else begin
            victim  <= miss_victim;
            k       <= '0;
            mem_req <= 1'b1;
            if (victim_dirty) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_addr(tag_mem[miss_victim][req_idx], req_idx, OFF0);
              mem_wdata <= data_mem[miss_victim][req_idx][OFF0];
              state     <= WB;
            end else begin
              mem_we   <= 1'b0;
              mem_addr <= word_addr(req_tag, req_idx, OFF0);
              state    <= FILL;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (&k) begin
              k        <= '0;
              mem_we   <= 1'b0;
              mem_addr <= word_addr(req_tag, req_idx, OFF0);
              state    <= FILL;
            end else begin
              k         <= k_next;
              mem_addr  <= word_addr(tag_mem[victim][req_idx], req_idx, k_next);
              mem_wdata <= data_mem[victim][req_idx][k_next];
            end
          end
        end
        FILL: begin
          // mem_req low means the read for word k has been accepted and is in flight.
          if (mem_req) begin
            if (mem_ack) mem_req <= 1'b0;
          end else if (mem_rvalid) begin
            if (&k) begin
              state <= RESOLVE;
            end else begin
              k        <= k_next;
              mem_req  <= 1'b1;
              mem_addr <= word_addr(req_tag, req_idx, k_next);
            end
          end
        end
        RESOLVE: begin
          valid[victim][req_idx] <= 1'b1;
          dirty[victim][req_idx] <= req_wr;
          lru[req_idx]           <= ~victim;
          if (!req_wr) DataOut <= data_mem[victim][req_idx][req_off];
          Done  <= 1'b1;
          Stall <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          err     <= 1'b1;
          Stall   <= 1'b0;
          mem_req <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag and data arrays
  always_ff @(posedge clk) begin
    if (rst && !mem_err) begin
      if (state == LOOKUP && hit && req_wr)
        data_mem[hit_way][req_idx][req_off] <= req_data;
      if (state == FILL && !mem_req && mem_rvalid)
        data_mem[victim][req_idx][k] <= mem_rdata;
      if (state == RESOLVE) begin
        tag_mem[victim][req_idx] <= req_tag;
        if (req_wr) data_mem[victim][req_idx][req_off] <= req_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_system_assoc.sv
// tb_mem_system_assoc: scoreboard bench for mem_system_assoc.
// A reference model of the cache (true-LRU list of resident lines per set plus a
// flat "processor view" memory) predicts hit/miss, load data and memory traffic
// for each request. Predictions are queued at issue time and a monitor process
// compares them whenever Done is seen. A second instance with WAYS=1 covers
// direct-mapped eviction.
module tb_mem_system_assoc;

  logic clk, rst;
  logic [15:0] Addr, DataIn, DataOut, mem_addr, mem_wdata, mem_rdata;
  logic Rd, Wr, Done, Stall, CacheHit, err, mem_req, mem_we, mem_ack, mem_rvalid, mem_err;

  logic [15:0] addr1, data_out1, maddr1, mwdata1, mrdata1;
  logic rd1, done1, stall1, hit1, err1, mreq1, mwe1, mack1, mrvalid1;

  mem_system_assoc #(.ADDR_W(16), .DATA_W(16), .INDEX_W(5), .OFFSET_W(2), .WAYS(2)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err));

  mem_system_assoc #(.ADDR_W(16), .DATA_W(16), .INDEX_W(5), .OFFSET_W(2), .WAYS(1)) dut1 (
    .clk(clk), .rst(rst), .Addr(addr1), .DataIn(16'h0000), .Rd(rd1), .Wr(1'b0),
    .DataOut(data_out1), .Done(done1), .Stall(stall1), .CacheHit(hit1), .err(err1),
    .mem_req(mreq1), .mem_we(mwe1), .mem_addr(maddr1), .mem_wdata(mwdata1),
    .mem_ack(mack1), .mem_rvalid(mrvalid1), .mem_rdata(mrdata1), .mem_err(1'b0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  function automatic void chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endfunction

  // ---------------- memories and reference model ----------------
  logic [15:0] M [logic [15:0]];   // backing memory written by the DUT
  logic [15:0] G [logic [15:0]];   // what a processor should read back

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction
  function automatic logic [15:0] mem_val(input logic [15:0] a);
    return M.exists(a) ? M[a] : init_val(a);
  endfunction
  function automatic logic [15:0] gold_val(input logic [15:0] a);
    return G.exists(a) ? G[a] : init_val(a);
  endfunction

  typedef struct { logic [7:0] tag; bit dirty; } line_t;
  line_t cs [32][$];   // resident lines per set, most recently used first

  typedef struct {
    bit is_err; bit hit; bit is_load; logic [15:0] data;
    int exp_rd; int exp_wr; int rd0; int wr0; int t0;
  } exp_t;
  exp_t sbq[$];

  typedef struct { bit hit; logic [15:0] data; } exp1_t;
  exp1_t q1[$];

  int n_rd = 0, n_wr = 0;
  logic [15:0] ra_log[$], wa_log[$], wd_log[$];

  function automatic exp_t model(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    int s, pos;
    line_t ln;
    e = '{default: 0};
    e.is_load = rd && !wr;
    if ((rd && wr) || a[0]) begin
      e.is_err = 1;
      return e;
    end
    s = int'(a[7:3]);
    pos = -1;
    for (int i = 0; i < cs[s].size(); i++) if (cs[s][i].tag == a[15:8]) pos = i;
    if (pos >= 0) begin
      e.hit = 1;
      ln = cs[s][pos];
      cs[s].delete(pos);
    end else begin
      e.exp_rd = 4;
      ln.tag = a[15:8];
      ln.dirty = 0;
      if (cs[s].size() == 2) begin
        if (cs[s][1].dirty) e.exp_wr = 4;
        void'(cs[s].pop_back());
      end
    end
    if (wr) begin
      ln.dirty = 1;
      G[a] = d;
    end else begin
      e.data = gold_val(a);
    end
    cs[s].push_front(ln);
    return e;
  endfunction

  // Reset loses dirty lines: the processor view falls back to backing memory.
  function automatic void model_reset();
    foreach (cs[s]) cs[s].delete();
    G = M;
  endfunction

  // ---------------- memory responder (random ack / rvalid delays) ----------------
  int ack_wait = 0, rd_wait = 0;
  bit rd_pend = 0;
  logic [15:0] rd_addr;
  initial begin
    mem_ack = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 0;
      mem_rvalid = 0;
      if (!rst) begin
        rd_pend = 0;
        ack_wait = $urandom_range(0, 5);
      end else if (rd_pend) begin
        if (rd_wait == 0) begin
          mem_rvalid = 1;
          mem_rdata = mem_val(rd_addr);
          rd_pend = 0;
        end else rd_wait--;
      end else if (mem_req) begin
        if (ack_wait == 0) begin
          mem_ack = 1;
          ack_wait = $urandom_range(0, 5);
          if (mem_we) begin
            M[mem_addr] = mem_wdata;
            wa_log.push_back(mem_addr);
            wd_log.push_back(mem_wdata);
            n_wr++;
          end else begin
            rd_pend = 1;
            rd_addr = mem_addr;
            rd_wait = $urandom_range(0, 4);
            ra_log.push_back(mem_addr);
            n_rd++;
          end
        end else ack_wait--;
      end
    end
  end

  // Simple responder for the WAYS=1 instance: immediate ack, data next cycle.
  bit pend1 = 0;
  logic [15:0] raddr1;
  initial begin
    mack1 = 0; mrvalid1 = 0; mrdata1 = 0;
    forever begin
      @(posedge clk); #1;
      mack1 = 0;
      mrvalid1 = 0;
      if (!rst) pend1 = 0;
      else if (pend1) begin
        mrvalid1 = 1;
        mrdata1 = init_val(raddr1);
        pend1 = 0;
      end else if (mreq1) begin
        mack1 = 1;
        if (!mwe1) begin
          pend1 = 1;
          raddr1 = maddr1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    exp1_t e1;
    forever begin
      @(negedge clk);
      if (rst && Done) begin
        if (sbq.size() == 0) fail_now("unexpected_done");
        else begin
          e = sbq.pop_front();
          chk("err", int'(err), int'(e.is_err));
          chk("cache_hit", int'(CacheHit), int'(e.hit));
          if (e.is_load && !e.is_err) chk("data_out", int'(DataOut), int'(e.data));
          chk("mem_reads", n_rd - e.rd0, e.exp_rd);
          chk("mem_writes", n_wr - e.wr0, e.exp_wr);
          if (e.is_err) chk("err_latency", cyc - e.t0, 1);
          else if (e.hit) chk("hit_latency", cyc - e.t0, 2);
        end
      end
      if (rst && done1) begin
        if (q1.size() == 0) fail_now("unexpected_done_w1");
        else begin
          e1 = q1.pop_front();
          chk("w1_cache_hit", int'(hit1), int'(e1.hit));
          chk("w1_data_out", int'(data_out1), int'(e1.data));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e = model(rd, wr, a, d);
    e.rd0 = n_rd;
    e.wr0 = n_wr;
    e.t0 = cyc;
    sbq.push_back(e);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      Rd = 0;
      Wr = 0;
      if (Done) return;
    end
    $display("FAIL timeout waiting for Done, addr=%h rd=%0d wr=%0d", a, rd, wr);
    n_cmp++;
    n_bad++;
  endtask

  task automatic issue1(input logic [15:0] a, input bit exp_hit);
    exp1_t e1;
    e1.hit = exp_hit;
    e1.data = init_val(a);
    q1.push_back(e1);
    rd1 = 1; addr1 = a;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      rd1 = 0;
      if (done1) return;
    end
    $display("FAIL timeout waiting for Done on WAYS=1 instance, addr=%h", a);
    n_cmp++;
    n_bad++;
  endtask

  initial begin
    int rn, wn, r;
    bit got;
    logic [15:0] a, d;
    rst = 0; Rd = 0; Wr = 0; Addr = 0; DataIn = 0; mem_err = 0; rd1 = 0; addr1 = 0;
    repeat (3) @(negedge clk);
    chk("rst_DataOut", int'(DataOut), 0);
    chk("rst_Done", int'(Done), 0);
    chk("rst_Stall", int'(Stall), 0);
    chk("rst_CacheHit", int'(CacheHit), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_mem_we", int'(mem_we), 0);
    rst = 1;
    @(negedge clk);

    // cold miss refills the whole line in word order, then a hit in the same line
    rn = ra_log.size();
    issue(1, 0, 16'h0010, 16'h0);
    chk("t1_nreads", ra_log.size() - rn, 4);
    if (ra_log.size() - rn == 4)
      for (int i = 0; i < 4; i++) chk("t1_read_addr", int'(ra_log[rn+i]), 16'h0010 + 2*i);
    issue(1, 0, 16'h0014, 16'h0);

    // three tags in set 2: LRU eviction
    issue(1, 0, 16'h0010, 16'h0);
    issue(1, 0, 16'h0110, 16'h0);
    issue(1, 0, 16'h0210, 16'h0);
    issue(1, 0, 16'h0110, 16'h0);
    issue(1, 0, 16'h0010, 16'h0);

    // dirty victim written back before the refill
    issue(0, 1, 16'h0020, 16'h1234);
    issue(0, 1, 16'h0120, 16'h5678);
    rn = ra_log.size();
    wn = wa_log.size();
    issue(1, 0, 16'h0220, 16'h0);
    chk("t3_nwrites", wa_log.size() - wn, 4);
    chk("t3_nreads", ra_log.size() - rn, 4);
    if (wa_log.size() - wn == 4 && ra_log.size() - rn == 4) begin
      chk("t3_wb_data0", int'(wd_log[wn]), 16'h1234);
      for (int i = 0; i < 4; i++) begin
        chk("t3_wb_addr", int'(wa_log[wn+i]), 16'h0020 + 2*i);
        chk("t3_fill_addr", int'(ra_log[rn+i]), 16'h0220 + 2*i);
      end
    end

    // malformed requests
    issue(1, 1, 16'h0010, 16'h0);
    issue(1, 0, 16'h0011, 16'h0);
    issue(0, 1, 16'h0023, 16'hBEEF);

    // randomized traffic over a few sets and tags
    for (int n = 0; n < 250; n++) begin
      a = {8'($urandom_range(0, 5)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0};
      d = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 3)       issue(1, 1, a, d);
      else if (r < 6)  issue(r[0], !r[0], a | 16'h1, d);
      else if (r < 54) issue(1, 0, a, 16'h0);
      else             issue(0, 1, a, d);
    end

    // memory fault during refill: sticky error until reset
    Rd = 1; Wr = 0; Addr = 16'h0030;
    @(negedge clk);
    Rd = 0;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      if (mem_req && !mem_we) got = 1;
      else @(negedge clk);
    end
    chk("t5_fill_reached", int'(got), 1);
    mem_err = 1;
    @(negedge clk);
    mem_err = 0;
    chk("t5_err", int'(err), 1);
    chk("t5_stall", int'(Stall), 0);
    chk("t5_mem_req", int'(mem_req), 0);
    Rd = 1; Addr = 16'h0010;
    @(negedge clk);
    Rd = 0;
    repeat (4) @(negedge clk);
    chk("t5_err_held", int'(err), 1);
    chk("t5_stall_held", int'(Stall), 0);
    chk("t5_done_low", int'(Done), 0);
    rst = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    chk("t5_rst_err", int'(err), 0);
    chk("t5_rst_mem_req", int'(mem_req), 0);
    issue(1, 0, 16'h0014, 16'h0);

    for (int n = 0; n < 60; n++) begin
      a = {8'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0};
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) issue(1, 0, a, 16'h0);
      else                           issue(0, 1, a, d);
    end

    // direct-mapped instance: conflicting tags evict each other
    issue1(16'h0010, 1'b0);
    issue1(16'h0110, 1'b0);
    issue1(16'h0010, 1'b0);
    issue1(16'h0012, 1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sbq.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
